// File: rtl/snn_pkg.sv
// snn_pkg: shared state type, default sizes and width helper for the SNN output decoder
package snn_pkg;
  typedef enum logic [1:0] {COUNT, SCAN, HOLD} state_t;
  localparam int N_OUT_CH = 4;
  localparam int T_WINDOW = 250;
  localparam int SPK_CNT_W = 8;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spike_counter_sat.sv
// spike_counter_sat: single-channel spike counter that sticks at all-ones instead of wrapping
module spike_counter_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en && i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a window, then scans for the rate-coded winner
module spike_rate_decoder #(
  parameter int N_CH     = snn_pkg::N_OUT_CH,
  parameter int T_WINDOW = snn_pkg::T_WINDOW,
  parameter int CNT_W    = snn_pkg::SPK_CNT_W,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_CH-1:0]  spikes,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] class_count,
  output logic             tie,
  output logic             no_spike,
  output logic             busy
);
  import snn_pkg::*;
  localparam int WIN_W = clog2(T_WINDOW);
  state_t           r_state;
  logic [WIN_W-1:0] r_win;
  logic [IDX_W-1:0] r_scan, r_best_idx;
  logic [CNT_W-1:0] r_best;
  logic             r_tie;
  logic [CNT_W-1:0] w_cnt [N_CH];
  logic [CNT_W-1:0] w_cur, w_best_n;
  logic [IDX_W-1:0] w_idx_n;
  logic             w_cnt_en, w_clr, w_take, w_tie_n, w_win_end;
  assign w_cnt_en  = r_state == COUNT && en;
  assign w_clr     = r_state == HOLD && ready;
  assign w_win_end = r_win == WIN_W'(T_WINDOW - 1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    spike_counter_sat #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_cnt_en),
      .i_clr (w_clr),
      .i_inc (spikes[i]),
      .o_cnt (w_cnt[i])
    );
  end
  // channel 0 seeds the running best; strict > keeps the lowest index on ties
  assign w_cur    = w_cnt[r_scan];
  assign w_take   = r_scan == '0 || w_cur > r_best;
  assign w_best_n = w_take ? w_cur : r_best;
  assign w_idx_n  = w_take ? r_scan : r_best_idx;
  assign w_tie_n  = w_take ? 1'b0 : (w_cur == r_best ? 1'b1 : r_tie);
  assign busy     = r_state != COUNT;
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= COUNT;
      r_win       <= '0;
      r_scan      <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_tie       <= 1'b0;
      valid       <= 1'b0;
      class_idx   <= '0;
      class_count <= '0;
      tie         <= 1'b0;
      no_spike    <= 1'b0;
    end else
      case (r_state)
        COUNT: if (en) begin
          r_win <= w_win_end ? '0 : r_win + 1'b1;
          if (w_win_end) begin
            r_state <= SCAN;
            r_scan  <= '0;
          end
        end
        SCAN: begin
          r_best     <= w_best_n;
          r_best_idx <= w_idx_n;
          r_tie      <= w_tie_n;
          r_scan     <= r_scan + 1'b1;
          if (r_scan == IDX_W'(N_CH - 1)) begin
            r_state     <= HOLD;
            valid       <= 1'b1;
            class_idx   <= w_idx_n;
            class_count <= w_best_n;
            tie         <= w_tie_n;
            no_spike    <= w_best_n == '0;
          end
        end
        HOLD: if (ready) begin
          r_state <= COUNT;
          valid   <= 1'b0;
        end
        default: r_state <= COUNT;
      endcase
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed and random windows checked against a count-and-argmax model
module tb_spike_rate_decoder;
  localparam int NC = 4, TW = 12, CW = 3, IW = 2;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst = 1, en = 0, ready = 0;
  logic [NC-1:0] spikes = '0;
  logic valid, tie, no_spike, busy;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] class_count;
  int errors = 0, checks = 0;
  logic [NC-1:0] pat[$];
  int m_idx, m_cnt;
  logic m_tie, m_ns;

  spike_rate_decoder #(.N_CH(NC), .T_WINDOW(TW), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .spikes(spikes), .ready(ready), .valid(valid),
    .class_idx(class_idx), .class_count(class_count), .tie(tie), .no_spike(no_spike), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mk(input int c0, input int c1, input int c2, input int c3);
    pat.delete();
    for (int t = 0; t < TW; t++) pat.push_back({t < c3, t < c2, t < c1, t < c0});
  endtask

  task automatic mk_rand;
    pat.delete();
    for (int t = 0; t < TW; t++) pat.push_back(4'($urandom));
  endtask

  task automatic model;
    int c[NC];
    int best, nbest;
    for (int i = 0; i < NC; i++) c[i] = 0;
    foreach (pat[t]) for (int i = 0; i < NC; i++) c[i] += int'(pat[t][i]);
    best = -1;
    nbest = 0;
    for (int i = 0; i < NC; i++) begin
      if (c[i] > SAT) c[i] = SAT;
      if (c[i] > best) begin
        best = c[i];
        m_idx = i;
      end
    end
    for (int i = 0; i < NC; i++) if (c[i] == best) nbest++;
    m_cnt = best;
    m_tie = nbest > 1;
    m_ns = best == 0;
  endtask

  task automatic feed(input bit gaps);
    foreach (pat[t]) begin
      if (gaps) begin
        en = 0;
        spikes = 4'($urandom);
        tick;
        chk("gap_busy", busy, 0);
      end
      en = 1;
      spikes = pat[t];
      tick;
    end
    chk("win_end", busy, 1);
  endtask

  task automatic result(input bit rdy);
    int n;
    model;
    ready = rdy;
    n = 0;
    while (!valid && n < 20) begin
      en = 1;
      spikes = 4'($urandom);
      tick;
      n++;
    end
    chk("latency", n, NC);
    chk("class_idx", class_idx, m_idx);
    chk("class_count", class_count, m_cnt);
    chk("tie", tie, m_tie);
    chk("no_spike", no_spike, m_ns);
  endtask

  task automatic ack;
    ready = 1;
    tick;
    chk("ack_valid", valid, 0);
    chk("ack_busy", busy, 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_count", class_count, 0);
    chk("rst_tie", tie, 0);
    chk("rst_ns", no_spike, 0);
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      en = 0;
      spikes = 4'($urandom);
      tick;
      chk("idle_busy", busy, 0);
    end
    chk("idle_valid", valid, 0);
    mk(2, 7, 3, 0); feed(0); result(1); ack;
    mk(0, 5, 0, 5); feed(0); result(1); ack;
    mk(0, 0, 0, 0); feed(0); result(1); ack;
    mk_rand; feed(0); result(0);
    for (int k = 0; k < 30; k++) begin
      en = 1;
      spikes = 4'($urandom);
      tick;
      chk("bp_valid", valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_idx", class_idx, m_idx);
      chk("bp_count", class_count, m_cnt);
      chk("bp_tie", tie, m_tie);
    end
    ack;
    mk(1, 2, 3, 4); feed(0); result(1); ack;
    mk(0, 0, 12, 0); feed(0); result(1); ack;
    mk(0, 0, 12, 0); feed(1); result(1); ack;
    for (int r = 0; r < 6; r++) begin
      mk_rand; feed(1'($urandom)); result(1); ack;
    end
    mk_rand; feed(0);
    en = 1;
    spikes = 4'($urandom);
    tick;
    rst = 1;
    tick;
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      en = 0;
      spikes = 4'($urandom);
      tick;
      chk("midrst_valid", valid, 0);
    end
    chk("midrst_busy", busy, 0);
    mk(3, 0, 1, 2); feed(0); result(1); ack;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
